// File: rtl/axi_lite_sram.sv
// AXI4-Lite word-addressed SRAM slave with independent read/write FSMs and fixed response latency.
// Define AXI_SRAM_RAND_DELAY_EN to add 0..3 LFSR-driven extra wait cycles per transaction.
module axi_lite_sram #(
  parameter int unsigned DEPTH   = 16384,
  parameter logic [31:0] BASE    = 32'h8000_0000,
  parameter int unsigned LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [7:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int unsigned IdxW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [1:0]  Okay   = 2'b00;
  localparam logic [1:0]  SlvErr = 2'b10;

  if (LATENCY > 15) begin : g_latency_check
    $error("axi_lite_sram: LATENCY must be in 0..15");
  end

  typedef enum logic [1:0] {RIdle, RWait, RResp} r_state_e;
  typedef enum logic [1:0] {WIdle, WWait, WResp} w_state_e;

  logic [31:0] mem [DEPTH];

  r_state_e    r_state_q, r_state_d;
  w_state_e    w_state_q, w_state_d;
  logic [3:0]  r_cnt_q, r_cnt_d, w_cnt_q, w_cnt_d, lat_load;
  logic [31:0] raddr_q, waddr_q, wdata_q, rdata_q;
  logic [3:0]  wstrb_q;
  logic [1:0]  rresp_q, bresp_q;
  logic        aw_got_q, w_got_q;

`ifdef AXI_SRAM_RAND_DELAY_EN
  logic [7:0] lfsr_q;
  logic [4:0] lat_sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= 8'hA5;
    else     lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  // Saturate so the 4-bit counter never wraps to a short wait.
  assign lat_sum  = 5'(LATENCY) + {3'b000, lfsr_q[1:0]};
  assign lat_load = lat_sum[4] ? 4'hF : lat_sum[3:0];
`else
  assign lat_load = 4'(LATENCY);
`endif

  // Read decode: with zero wait the response is built straight from the live address.
  logic [31:0]     r_addr, r_off;
  logic            r_in, r_enter;
  logic [IdxW-1:0] r_idx;

  assign r_addr  = (r_state_q == RIdle) ? araddr : raddr_q;
  assign r_off   = r_addr - BASE;
  assign r_in    = (r_addr >= BASE) && ({2'b00, r_off[31:2]} < 32'(DEPTH));
  assign r_idx   = r_off[IdxW+1:2];
  assign r_enter = (r_state_q != RResp) && (r_state_d == RResp);

  // Write decode: captured values win over the live bus once held.
  logic            aw_hs, w_hs, aw_have, w_have, w_in, w_enter, w_commit;
  logic [31:0]     w_addr, w_data, w_off;
  logic [3:0]      w_strb;
  logic [IdxW-1:0] w_idx;

  assign aw_hs    = (w_state_q == WIdle) && !aw_got_q && awvalid;
  assign w_hs     = (w_state_q == WIdle) && !w_got_q && wvalid;
  assign aw_have  = aw_got_q || aw_hs;
  assign w_have   = w_got_q || w_hs;
  assign w_addr   = aw_got_q ? waddr_q : awaddr;
  assign w_data   = w_got_q ? wdata_q : wdata;
  assign w_strb   = w_got_q ? wstrb_q : wstrb[3:0];
  assign w_off    = w_addr - BASE;
  assign w_in     = (w_addr >= BASE) && ({2'b00, w_off[31:2]} < 32'(DEPTH));
  assign w_idx    = w_off[IdxW+1:2];
  assign w_enter  = (w_state_q != WResp) && (w_state_d == WResp);
  assign w_commit = w_enter && w_in && !rst;

  logic unused_bits;
  assign unused_bits = ^{r_off[1:0], w_off[1:0], wstrb[7:4]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_q <= RIdle;
      w_state_q <= WIdle;
      r_cnt_q   <= 4'd0;
      w_cnt_q   <= 4'd0;
    end else begin
      r_state_q <= r_state_d;
      w_state_q <= w_state_d;
      r_cnt_q   <= r_cnt_d;
      w_cnt_q   <= w_cnt_d;
    end
  end

  always_comb begin
    r_state_d = r_state_q;
    r_cnt_d   = r_cnt_q;
    unique case (r_state_q)
      RIdle: if (arvalid) begin
        r_cnt_d   = lat_load;
        r_state_d = (lat_load == 4'd0) ? RResp : RWait;
      end
      RWait: begin
        r_cnt_d = r_cnt_q - 4'd1;
        if (r_cnt_q == 4'd1) r_state_d = RResp;
      end
      RResp:   if (rready) r_state_d = RIdle;
      default: r_state_d = RIdle;
    endcase
  end

  always_comb begin
    w_state_d = w_state_q;
    w_cnt_d   = w_cnt_q;
    unique case (w_state_q)
      WIdle: if (aw_have && w_have) begin
        w_cnt_d   = lat_load;
        w_state_d = (lat_load == 4'd0) ? WResp : WWait;
      end
      WWait: begin
        w_cnt_d = w_cnt_q - 4'd1;
        if (w_cnt_q == 4'd1) w_state_d = WResp;
      end
      WResp:   if (bready) w_state_d = WIdle;
      default: w_state_d = WIdle;
    endcase
  end

  always_comb begin
    arready = (r_state_q == RIdle);
    rvalid  = (r_state_q == RResp);
    awready = (w_state_q == WIdle) && !aw_got_q;
    wready  = (w_state_q == WIdle) && !w_got_q;
    bvalid  = (w_state_q == WResp);
  end

  assign rdata = rdata_q;
  assign rresp = rresp_q;
  assign bresp = bresp_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      raddr_q  <= 32'd0;
      rdata_q  <= 32'd0;
      rresp_q  <= Okay;
      waddr_q  <= 32'd0;
      wdata_q  <= 32'd0;
      wstrb_q  <= 4'd0;
      aw_got_q <= 1'b0;
      w_got_q  <= 1'b0;
      bresp_q  <= Okay;
    end else begin
      if ((r_state_q == RIdle) && arvalid) raddr_q <= araddr;
      if (r_enter) begin
        rdata_q <= r_in ? mem[r_idx] : 32'd0;
        rresp_q <= r_in ? Okay : SlvErr;
      end
      if (aw_hs) waddr_q <= awaddr;
      if (w_hs) begin
        wdata_q <= wdata;
        wstrb_q <= wstrb[3:0];
      end
      if ((w_state_q == WResp) && bready) begin
        aw_got_q <= 1'b0;
        w_got_q  <= 1'b0;
      end else begin
        if (aw_hs) aw_got_q <= 1'b1;
        if (w_hs)  w_got_q  <= 1'b1;
      end
      if (w_enter) bresp_q <= w_in ? Okay : SlvErr;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int i = 0; i < 4; i++) begin
        if (w_strb[i]) mem[w_idx][8*i +: 8] <= w_data[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_sram.sv
// Self-checking bench for axi_lite_sram: transaction-level memory model checked every cycle,
// plus directed transactions with literal expected results.
module tb_axi_lite_sram;

  localparam int unsigned DEPTH = 16384;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          LAT   = 2;

  logic        clk, rst;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic        arvalid, arready, rvalid, rready;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [1:0]  rresp, bresp;
  logic [7:0]  wstrb;

  axi_lite_sram #(.DEPTH(DEPTH), .BASE(BASE), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, got, exp);
  endtask

  task automatic check1(input string name, input logic got, input logic exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b", name, got, exp);
  endtask

  task automatic timeout(input string name);
    n_checks++;
    $display("FAIL timeout %s: got no handshake, expected one within bound", name);
  endtask

  // ---------------- transaction-level model ----------------
  logic [31:0] mem_m [int unsigned];
  bit          r_busy, r_known, aw_got, w_got;
  logic [31:0] r_exp_d, m_awaddr, m_wdata;
  logic [1:0]  r_exp_r;
  logic [3:0]  m_wstrb;
  int          ar_cyc, wb_cyc, ncyc;

  function automatic bit m_in_range(input logic [31:0] a);
    if (a < BASE) return 1'b0;
    return ((64'(a) - 64'(BASE)) / 4) < 64'(DEPTH);
  endfunction

  function automatic int unsigned m_idx(input logic [31:0] a);
    return int'((a - BASE) / 4);
  endfunction

  always @(negedge clk) begin
    ncyc++;
    if (rst) begin
      check1("rst_arready", arready, 1'b1);
      check1("rst_awready", awready, 1'b1);
      check1("rst_wready", wready, 1'b1);
      check1("rst_rvalid", rvalid, 1'b0);
      check1("rst_bvalid", bvalid, 1'b0);
      check32("rst_rdata", rdata, 32'h0);
      check32("rst_rresp", 32'(rresp), 32'h0);
      check32("rst_bresp", 32'(bresp), 32'h0);
      r_busy = 0;
      aw_got = 0;
      w_got  = 0;
    end else begin
      check1("arready", arready, !r_busy);
      check1("rvalid", rvalid, r_busy && (ncyc - ar_cyc >= LAT + 1));
      if (rvalid && r_busy) begin
        if (r_known) check32("rdata", rdata, r_exp_d);
        check32("rresp", 32'(rresp), 32'(r_exp_r));
      end
      check1("awready", awready, !aw_got);
      check1("wready", wready, !w_got);
      check1("bvalid", bvalid, aw_got && w_got && (ncyc - wb_cyc >= LAT + 1));
      if (bvalid && aw_got && w_got)
        check32("bresp", 32'(bresp), m_in_range(m_awaddr) ? 32'h0 : 32'h2);

      // Handshakes that complete on the coming rising edge.
      if (arvalid && arready && !r_busy) begin
        r_busy = 1;
        ar_cyc = ncyc;
        if (m_in_range(araddr)) begin
          r_known = mem_m.exists(m_idx(araddr));
          r_exp_d = r_known ? mem_m[m_idx(araddr)] : 32'h0;
          r_exp_r = 2'b00;
        end else begin
          r_known = 1;
          r_exp_d = 32'h0;
          r_exp_r = 2'b10;
        end
      end else if (rvalid && rready && r_busy) begin
        r_busy = 0;
      end

      if (bvalid && bready && aw_got && w_got) begin
        if (m_in_range(m_awaddr)) begin
          logic [31:0] word;
          word = mem_m.exists(m_idx(m_awaddr)) ? mem_m[m_idx(m_awaddr)] : 32'h0;
          for (int i = 0; i < 4; i++)
            if (m_wstrb[i]) word[8*i +: 8] = m_wdata[8*i +: 8];
          mem_m[m_idx(m_awaddr)] = word;
        end
        aw_got = 0;
        w_got  = 0;
      end else begin
        if (awvalid && awready && !aw_got) begin
          aw_got   = 1;
          m_awaddr = awaddr;
          if (w_got) wb_cyc = ncyc;
        end
        if (wvalid && wready && !w_got) begin
          w_got   = 1;
          m_wdata = wdata;
          m_wstrb = wstrb[3:0];
          if (aw_got) wb_cyc = ncyc;
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [7:0] s,
                           input int aw_dly, input int w_dly, output logic [1:0] resp);
    bit aw_done = 0, w_done = 0, fire_aw, fire_w;
    int t = 0, g = 0;
    awaddr = a;
    wdata  = d;
    wstrb  = s;
    while (!(aw_done && w_done) && t < 60) begin
      awvalid = !aw_done && (t >= aw_dly);
      wvalid  = !w_done && (t >= w_dly);
      fire_aw = awvalid && awready;
      fire_w  = wvalid && wready;
      @(posedge clk); #1;
      aw_done |= fire_aw;
      w_done  |= fire_w;
      t++;
    end
    awvalid = 0;
    wvalid  = 0;
    resp    = 2'bxx;
    if (!(aw_done && w_done)) begin
      timeout("aw_w");
      return;
    end
    bready = 1;
    while (!bvalid && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    if (!bvalid) begin
      timeout("b");
      bready = 0;
      return;
    end
    resp = bresp;
    @(posedge clk); #1;
    bready = 0;
  endtask

  task automatic axi_read(input logic [31:0] a, input int hold,
                          output logic [31:0] d, output logic [1:0] resp);
    int g = 0;
    d       = 32'hx;
    resp    = 2'bxx;
    araddr  = a;
    arvalid = 1;
    while (!arready && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    if (!arready) begin
      timeout("ar");
      arvalid = 0;
      return;
    end
    @(posedge clk); #1;
    arvalid = 0;
    g = 0;
    while (!rvalid && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    if (!rvalid) begin
      timeout("r");
      return;
    end
    repeat (hold) begin
      @(posedge clk); #1;
    end
    rready = 1;
    d      = rdata;
    resp   = rresp;
    @(posedge clk); #1;
    rready = 0;
  endtask

  logic [31:0] rd;
  logic [1:0]  rs, bs;

  initial begin
    rst = 1; araddr = 0; arvalid = 0; rready = 0;
    awaddr = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0; bready = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(posedge clk); #1;

    // Basic write then read.
    axi_write(32'h8000_0010, 32'hDEAD_BEEF, 8'h0F, 0, 0, bs);
    check32("wr_basic_bresp", 32'(bs), 32'h0);
    axi_read(32'h8000_0010, 0, rd, rs);
    check32("rd_basic_data", rd, 32'hDEAD_BEEF);
    check32("rd_basic_resp", 32'(rs), 32'h0);

    // Byte strobes; upper strobe bits have no effect.
    axi_write(32'h8000_0020, 32'h1122_3344, 8'h0F, 0, 0, bs);
    axi_write(32'h8000_0020, 32'hAABB_CCDD, 8'h05, 0, 0, bs);
    axi_read(32'h8000_0020, 0, rd, rs);
    check32("rd_strobe", rd, 32'h11BB_33DD);
    axi_write(32'h8000_0020, 32'hFFFF_FFFF, 8'hF0, 0, 0, bs);
    check32("wr_hi_strobe_bresp", 32'(bs), 32'h0);
    axi_read(32'h8000_0020, 0, rd, rs);
    check32("rd_hi_strobe", rd, 32'h11BB_33DD);

    // Channel skew in both directions.
    axi_write(32'h8000_0030, 32'h0BAD_F00D, 8'h0F, 0, 3, bs);
    check32("wr_aw_first_bresp", 32'(bs), 32'h0);
    axi_write(32'h8000_0034, 32'h600D_CAFE, 8'h0F, 2, 0, bs);
    check32("wr_w_first_bresp", 32'(bs), 32'h0);
    axi_read(32'h8000_0030, 0, rd, rs);
    check32("rd_aw_first", rd, 32'h0BAD_F00D);
    axi_read(32'h8000_0034, 0, rd, rs);
    check32("rd_w_first", rd, 32'h600D_CAFE);

    // Back-pressure on R.
    axi_read(32'h8000_0010, 5, rd, rs);
    check32("rd_backpressure", rd, 32'hDEAD_BEEF);

    // Range boundaries.
    axi_write(32'h8000_0000, 32'h5A5A_5A5A, 8'h0F, 0, 0, bs);
    axi_write(32'h8000_FFFC, 32'h0123_4567, 8'h0F, 0, 0, bs);
    check32("wr_last_bresp", 32'(bs), 32'h0);
    axi_read(32'h8000_FFFC, 0, rd, rs);
    check32("rd_last_word", rd, 32'h0123_4567);
    axi_read(32'h7FFF_FFFC, 0, rd, rs);
    check32("rd_oor_data", rd, 32'h0);
    check32("rd_oor_resp", 32'(rs), 32'h2);
    axi_write(BASE + DEPTH * 4, 32'hFFFF_FFFF, 8'h0F, 0, 0, bs);
    check32("wr_oor_bresp", 32'(bs), 32'h2);
    axi_read(32'h8000_0000, 0, rd, rs);
    check32("rd_word0_unchanged", rd, 32'h5A5A_5A5A);

    // Reset while both FSMs are waiting.
    axi_write(32'h8000_0040, 32'hCAFE_F00D, 8'h0F, 0, 0, bs);
    araddr = 32'h8000_0040; arvalid = 1;
    awaddr = 32'h8000_0040; awvalid = 1;
    wdata  = 32'h1234_5678; wstrb = 8'h0F; wvalid = 1;
    @(posedge clk); #1;
    arvalid = 0; awvalid = 0; wvalid = 0;
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    check1("post_rst_arready", arready, 1'b1);
    check1("post_rst_awready", awready, 1'b1);
    check1("post_rst_wready", wready, 1'b1);
    @(posedge clk); #1;
    axi_read(32'h8000_0040, 0, rd, rs);
    check32("rd_after_abort", rd, 32'hCAFE_F00D);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/axi_lite_sram.md
Name: axi_lite_sram

Overview:
- AXI4-Lite memory slave directly downstream of the core's read/write arbiter; serves every IFU instruction fetch and LSU load/store the arbiter forwards.
- Provides a synthesizable word-addressed SRAM with configurable response latency, so the handshake logic in the IFU and LSU can be exercised without DPI memory calls.
- Read and write channels are independent state machines sharing one storage array.

Parameters:
- DEPTH, 16384, number of 32-bit words stored.
- BASE, 32'h80000000, byte address of word 0.
- LATENCY, 1, wait cycles between address acceptance and response (0..15).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- araddr  in  32  read byte address.
- arvalid  in  1  read address valid.
- arready  out  1  read address ready.
- rdata  out  32  read data.
- rresp  out  2  read response: 00 OKAY, 10 SLVERR.
- rvalid  out  1  read data valid.
- rready  in  1  read data ready.
- awaddr  in  32  write byte address.
- awvalid  in  1  write address valid.
- awready  out  1  write address ready.
- wdata  in  32  write data.
- wstrb  in  8  byte strobes; bits [3:0] used, bits [7:4] ignored.
- wvalid  in  1  write data valid.
- wready  out  1  write data ready.
- bresp  out  2  write response: 00 OKAY, 10 SLVERR.
- bvalid  out  1  write response valid.
- bready  in  1  write response ready.

Behaviour:
- Reset (async, active-high): read FSM to R_IDLE, write FSM to W_IDLE, delay counters to 0.
  - Outputs during/after reset: arready=1, awready=1, wready=1, rvalid=0, bvalid=0, rdata=0, rresp=00, bresp=00.
  - Memory contents are not reset.
- Address decode:
  - Word index = (addr - BASE) >> 2; addr[1:0] ignored.
  - Out of range when addr < BASE or index >= DEPTH.
- Read FSM: R_IDLE -> R_WAIT -> R_RESP.
  - R_IDLE: arready=1. On arvalid&&arready, latch araddr and load counter=LATENCY. Go to R_WAIT, or straight to R_RESP if LATENCY==0.
  - R_WAIT: arready=0. Counter decrements each cycle; on reaching 0, go to R_RESP.
  - Entering R_RESP: register rdata=mem[index] and rresp=00. If out of range: rdata=0, rresp=10.
  - R_RESP: rvalid=1, and rdata/rresp stay stable until rready. On rvalid&&rready, return to R_IDLE and set arready=1 the next cycle.
  - No back-to-back acceptance in the handshake cycle.
  - Minimum read latency, AR handshake to rvalid: LATENCY+1 cycles.
- Write FSM: W_IDLE -> W_WAIT -> W_RESP.
  - W_IDLE: awready=1 until AW is captured; wready=1 until W is captured. AW and W may arrive in the same cycle or in either order; each is held once captured.
  - When both are captured, load counter=LATENCY and go to W_WAIT, or straight to W_RESP if LATENCY==0.
  - W_WAIT: awready=0, wready=0; counter decrements.
  - Entering W_RESP: commit the write. For each i in 0..3, if wstrb[i], write byte i of wdata. bresp=00.
  - Out of range: no write, bresp=10.
  - W_RESP: bvalid=1 until bready. On handshake, return to W_IDLE.
- Simultaneous events:
  - Both FSMs run concurrently.
  - Read entering R_RESP in the same cycle a write commits to the same word: the read returns the old data.
  - Write committing and read sampling one cycle later: the read returns the new data.
- Reset asserted mid-transaction aborts it. A pending write that has not yet reached W_RESP is never committed.
- Counter is 4 bits wide. LATENCY values above 15 are an error, caught by an elaboration-time check.

Optional Feature:
- Macro: AXI_SRAM_RAND_DELAY_EN.
- When defined:
  - An 8-bit LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5 at reset) advances every cycle.
  - At each address acceptance, counter loads LATENCY + lfsr[1:0] instead of LATENCY.
  - Read and write sample the same LFSR value if accepted in the same cycle.
- When undefined: no LFSR exists and latency is exactly LATENCY.

Test Plan:
- Reset, then write 0xDEADBEEF to 0x80000010 with wstrb=0xF, then read 0x80000010 -> bresp=00; rdata=0xDEADBEEF, rresp=00; rvalid asserts exactly LATENCY+1 cycles after the AR handshake.
- Byte strobes: preload 0x11223344 at 0x80000020, write 0xAABBCCDD with wstrb=0x5 -> a later read returns 0x11BB33DD.
- AW sent 3 cycles before W, then W sent 2 cycles before AW -> each channel is captured independently; exactly one bvalid per write; data is correct in both cases.
- Back-pressure: hold rready=0 for 5 cycles with rvalid high -> rdata and rresp stay constant and arready stays 0 until the handshake.
- Out of range: read 0x7FFFFFFC and write 0x80000000+DEPTH*4 -> rresp=10 with rdata=0; bresp=10; memory unchanged.
- Reset asserted while in R_WAIT and in W_WAIT -> both FSMs idle, arready=awready=wready=1, the target word keeps its old value.
